// File: rtl/bus_fabric_if.sv
// Bus fabric signal bundle: master-side request/response and slave-side select/ack.
// The fabric modport is the crossbar's own view of both sides.
interface bus_fabric_if #(
  parameter int N_M = 3,
  parameter int N_S = 2,
  parameter int DW  = 32,
  parameter int SW  = 3
);
  logic [N_M-1:0]    req;
  logic [N_M*SW-1:0] slave_id;
  logic [N_M*DW-1:0] m_data_out;
  logic [N_M-1:0]    gnt;
  logic              ack;
  logic              err;
  logic [DW-1:0]     m_data_in;
  logic [N_S-1:0]    s_sel;
  logic [DW-1:0]     s_wdata;
  logic [N_S-1:0]    s_ack;
  logic [N_S*DW-1:0] s_rdata;

  modport master (
    output req, slave_id, m_data_out,
    input  gnt, ack, err, m_data_in
  );

  modport slave (
    input  s_sel, s_wdata,
    output s_ack, s_rdata
  );

  modport fabric (
    input  req, slave_id, m_data_out,
    output gnt, ack, err, m_data_in,
    output s_sel, s_wdata,
    input  s_ack, s_rdata
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-transaction N_M x N_S bus fabric with round-robin or fixed arbitration
// and a per-transaction BUSY timeout that completes with an error pulse.
module bus_fabric #(
  parameter int N_M      = 3,
  parameter int N_S      = 2,
  parameter int DW       = 32,
  parameter int SW       = 3,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 16
) (
  input logic          clk,
  input logic          rst,
  bus_fabric_if.fabric bus
);
  localparam int MW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [N_M-1:0] gnt_q, gnt_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [SW-1:0]  id_q, id_d;
  logic [MW-1:0]  win_q, win_d;
  logic [MW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [MW-1:0]  win;
  logic [N_S-1:0] sel;
  logic [DW-1:0]  sel_rdata;
  logic           hit;

  // first requester scanning upward from base, wrapping at N_M
  function automatic logic [MW-1:0] arb_pick(
    input logic [N_M-1:0] r,
    input logic [MW-1:0]  base
  );
    logic [MW-1:0] w;
    logic          found;
    int            k;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_M; i++) begin
      k = int'(base) + i;
      if (k >= N_M) k = k - N_M;
      if (!found && r[k]) begin
        w     = MW'(k);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = arb_pick(bus.req, (ARB_MODE != 0) ? ptr_q : '0);

  always_comb begin
    sel       = '0;
    sel_rdata = '0;
    for (int j = 0; j < N_S; j++) begin
      if (state_q == BUSY && int'(id_q) == j) sel[j] = 1'b1;
    end
    for (int j = 0; j < N_S; j++) begin
      if (sel[j]) sel_rdata = sel_rdata | bus.s_rdata[j*DW +: DW];
    end
    hit = |(sel & bus.s_ack);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    id_d    = id_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          id_d       = bus.slave_id[win*SW +: SW];
          cnt_d      = '0;
          ptr_d      = (win == MW'(N_M - 1)) ? '0 : win + 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (hit) begin
          ack_d   = 1'b1;
          rdata_d = sel_rdata;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (~|sel || cnt_q == CW'(TIMEOUT - 1)) begin
          // no addressable slave or timeout: error completion
          ack_d   = 1'b1;
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      id_q    <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      id_q    <= id_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.m_data_in = rdata_q;
  assign bus.s_sel     = sel;
  assign bus.s_wdata   = (state_q == BUSY) ?
                         bus.m_data_out[win_q*DW +: DW] : '0;
endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench: stimulus queues expected completions, monitors pop on ack.
// One round-robin instance with a programmable slave, one fixed-priority instance.
module tb_bus_fabric;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_fabric_if #(.N_M(3), .N_S(2), .DW(32), .SW(3)) rr_if ();
  bus_fabric_if #(.N_M(3), .N_S(2), .DW(32), .SW(3)) fp_if ();

  bus_fabric #(.N_M(3), .N_S(2), .DW(32), .SW(3),
               .ARB_MODE(1), .TIMEOUT(16))
    dut_rr (.clk(clk), .rst(rst), .bus(rr_if));

  bus_fabric #(.N_M(3), .N_S(2), .DW(32), .SW(3),
               .ARB_MODE(0), .TIMEOUT(16))
    dut_fp (.clk(clk), .rst(rst), .bus(fp_if));

  typedef struct {
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          selcnt;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int total = 0;
  int bad = 0;
  int ack_rr = 0;
  int ack_fp = 0;

  int delay = 0;
  bit noisy = 1'b0;

  assign rr_if.s_rdata = {32'h0000_00BB, 32'h0000_00AA};
  assign fp_if.s_rdata = {32'h0000_00BB, 32'h0000_00AA};
  assign fp_if.s_ack   = fp_if.s_sel;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_rr(input logic [2:0] g, input logic [1:0] s,
                         input logic [31:0] w, input logic e,
                         input logic [31:0] r, input int n);
    exp_t x;
    x.gnt = g; x.sel = s; x.wdata = w;
    x.err = e; x.rdata = r; x.selcnt = n;
    q_rr.push_back(x);
  endtask

  // slave acks on its delay-th selected cycle; noisy acks every unselected slave
  initial begin
    int sc;
    sc = 0;
    rr_if.s_ack = '0;
    forever begin
      @(negedge clk);
      if (rr_if.s_sel != '0) begin
        rr_if.s_ack = ((sc == delay) ? rr_if.s_sel : 2'b00) |
                      (noisy ? ~rr_if.s_sel : 2'b00);
        sc++;
      end else begin
        rr_if.s_ack = '0;
        sc = 0;
      end
    end
  end

  initial begin
    int sel_cnt;
    logic [2:0] cur_gnt;
    exp_t e;
    sel_cnt = 0;
    cur_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rr_if.gnt != '0) cur_gnt = rr_if.gnt;
        if (rr_if.s_sel != '0) begin
          sel_cnt++;
          if (sel_cnt == 1 && q_rr.size() > 0) begin
            chk("rr_sel", rr_if.s_sel, q_rr[0].sel);
            chk("rr_wdata", rr_if.s_wdata, q_rr[0].wdata);
          end
        end
        if (rr_if.ack) begin
          ack_rr++;
          if (q_rr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rr_unexpected_ack: got ack=1 want 0");
          end else begin
            e = q_rr.pop_front();
            chk("rr_gnt", cur_gnt, e.gnt);
            chk("rr_err", rr_if.err, e.err);
            chk("rr_rdata", rr_if.m_data_in, e.rdata);
            chk("rr_sel_cycles", sel_cnt, e.selcnt);
          end
          sel_cnt = 0;
        end else begin
          chk("rr_idle_err", rr_if.err, 1'b0);
          chk("rr_idle_data", rr_if.m_data_in, 32'h0);
          if (rr_if.s_sel == '0) sel_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [2:0] cur_gnt;
    exp_t e;
    cur_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fp_if.gnt != '0) cur_gnt = fp_if.gnt;
        if (fp_if.ack) begin
          ack_fp++;
          if (q_fp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fp_unexpected_ack: got ack=1 want 0");
          end else begin
            e = q_fp.pop_front();
            chk("fp_gnt", cur_gnt, e.gnt);
            chk("fp_err", fp_if.err, e.err);
            chk("fp_rdata", fp_if.m_data_in, e.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int tgt, input bit fp);
    int n;
    n = 0;
    while (((fp ? ack_fp : ack_rr) < tgt) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if ((fp ? ack_fp : ack_rr) < tgt) begin
      total++;
      bad++;
      $display("FAIL ack_wait: got %0d acks want %0d", fp ? ack_fp : ack_rr, tgt);
    end
  endtask

  task automatic run_rr(input logic [2:0] r, input int n, input bit hold);
    int tgt;
    tgt = ack_rr + n;
    @(negedge clk);
    rr_if.req = r;
    if (!hold) begin
      @(negedge clk);
      rr_if.req = '0;
    end
    wait_ack(tgt, 1'b0);
    rr_if.req = '0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rr_if.req        = '0;
    rr_if.slave_id   = {3'd0, 3'd1, 3'd0};
    rr_if.m_data_out = {32'h33, 32'h22, 32'h11};
    fp_if.req        = '0;
    fp_if.slave_id   = {3'd0, 3'd1, 3'd0};
    fp_if.m_data_out = {32'h33, 32'h22, 32'h11};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", rr_if.gnt, 3'b000);
    chk("rst_ack", rr_if.ack, 1'b0);
    chk("rst_err", rr_if.err, 1'b0);
    chk("rst_data", rr_if.m_data_in, 32'h0);
    chk("rst_sel", rr_if.s_sel, 2'b00);
    chk("rst_wdata", rr_if.s_wdata, 32'h0);

    push_rr(3'b001, 2'b01, 32'h11, 1'b0, 32'hAA, 1);
    run_rr(3'b001, 1, 1'b1);

    pulse_rst();
    push_rr(3'b001, 2'b01, 32'h11, 1'b0, 32'hAA, 1);
    push_rr(3'b010, 2'b10, 32'h22, 1'b0, 32'hBB, 1);
    push_rr(3'b100, 2'b01, 32'h33, 1'b0, 32'hAA, 1);
    push_rr(3'b001, 2'b01, 32'h11, 1'b0, 32'hAA, 1);
    run_rr(3'b111, 4, 1'b1);

    delay = 99;
    push_rr(3'b010, 2'b10, 32'h22, 1'b1, 32'h0, 16);
    run_rr(3'b010, 1, 1'b1);

    delay = 15;
    push_rr(3'b100, 2'b01, 32'h33, 1'b0, 32'hAA, 16);
    run_rr(3'b100, 1, 1'b0);

    delay = 99;
    noisy = 1'b1;
    push_rr(3'b001, 2'b01, 32'h11, 1'b1, 32'h0, 16);
    run_rr(3'b001, 1, 1'b1);
    noisy = 1'b0;

    delay = 0;
    rr_if.slave_id = {3'd0, 3'd5, 3'd0};
    push_rr(3'b010, 2'b00, 32'h22, 1'b1, 32'h0, 0);
    run_rr(3'b010, 1, 1'b1);
    rr_if.slave_id = {3'd0, 3'd1, 3'd0};

    delay = 99;
    @(negedge clk);
    rr_if.req = 3'b010;
    repeat (4) @(negedge clk);
    rr_if.req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_gnt", rr_if.gnt, 3'b000);
    chk("abort_sel", rr_if.s_sel, 2'b00);
    chk("abort_ack", rr_if.ack, 1'b0);
    chk("abort_wdata", rr_if.s_wdata, 32'h0);
    delay = 0;
    push_rr(3'b001, 2'b01, 32'h11, 1'b0, 32'hAA, 1);
    run_rr(3'b111, 1, 1'b1);

    begin
      exp_t x;
      x.gnt = 3'b001; x.sel = 2'b01; x.wdata = 32'h11;
      x.err = 1'b0; x.rdata = 32'hAA; x.selcnt = 1;
      repeat (3) q_fp.push_back(x);
      @(negedge clk);
      fp_if.req = 3'b111;
      wait_ack(3, 1'b1);
      fp_if.req = '0;
    end

    repeat (4) @(negedge clk);
    chk("rr_queue_drained", q_rr.size(), 0);
    chk("fp_queue_drained", q_fp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
